pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
Parametrised pipeline stage buffer carrying one instruction plus its decoded control bundle between two CPU stages. Successor to the plain always-capture stage register. Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops an instruction. Adds synchronous flush for branch squash, and bubble masking so invalid slots cannot write state.

Parameters:
INSTR_W, 16, instruction width in bits
BRANCH_OP_W, 2, branch-op field width
ALU_OP_W, 4, ALU-op field width
NOP_INSTR, 16'h0000 (INSTR_W bits), instruction value presented in empty slots and after reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream offers an entry
in_ready  output  1  buffer can accept; registered
instr_in  input  INSTR_W  instruction
branch_op_in  input  BRANCH_OP_W  branch op
alu_op_in  input  ALU_OP_W  ALU op
mux3_sel_in  input  1  mux3 select
r0_write_in  input  1  R0 write enable
reg_write_in  input  1  register-file write enable
w_enable_in  input  1  memory write enable
out_valid  output  1  head entry valid
out_ready  input  1  downstream consumes head
instr_out, branch_op_out, alu_op_out, mux3_sel_out, r0_write_out, reg_write_out, w_enable_out  output  matching widths  head entry fields

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Storage: main slot (drives outputs) plus skid slot; each has its own valid bit.
- Occupancy states:
  - EMPTY: no valid entries.
  - ONE: main valid.
  - FULL: main and skid valid.
- Handshake events:
  - Accept = in_valid && in_ready.
  - Drain = out_valid && out_ready.
- in_ready = !skid_valid, registered; it is never a combinational function of out_ready.
- Transitions when flush=0:
  - EMPTY: accept -> ONE (data into main).
  - ONE: accept only -> FULL (data into skid). Drain only -> EMPTY. Accept and drain together -> ONE (new data into main).
  - FULL: drain -> ONE (skid moves to main, skid cleared). in_ready=0, so no accept.
- Latency: an entry accepted at edge N is visible on the outputs after edge N (1-cycle latency when unstalled). Throughput is 1 per cycle while out_ready=1.
- Ordering is strictly FIFO; no entry is duplicated or dropped.
- Flush:
  - Highest priority: at the edge, both valid bits clear and the state becomes EMPTY.
  - Any entry accepted in the same cycle is discarded.
  - in_ready = 1 the following cycle.
- Bubble masking:
  - When out_valid=0, r0_write_out, reg_write_out and w_enable_out are forced 0 and instr_out = NOP_INSTR.
  - Other fields hold their last data.
- Reset, mid-operation included, takes effect immediately:
  - All valid bits 0; in_ready 0 while rst_n low, 1 from the first edge after release.
  - instr_out = NOP_INSTR.
  - All control outputs 0; data regs 0.
- Data regs load only on accept or skid-to-main move, so there is no toggling on idle cycles.

Optional Feature:
Macro PIPE_STAGE_BUF_STATS_EN.
- Defined: adds output ports stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments each cycle out_valid && !out_ready.
  - flush_cnt increments each cycle flush=1.
  - Both saturate at 16'hFFFF and reset to 0 on rst_n.
- Undefined: ports and counters absent; the rest of the behaviour is identical.

Test Plan:
- Streaming: reset, out_ready=1, present instr 16'h1234, 16'h5678, 16'h9ABC on consecutive cycles -> each appears on instr_out one cycle after accept, out_valid high 3 cycles, in_ready stays 1.
- Back-pressure: out_ready=0, offer 16'hA001, 16'hA002, 16'hA003 -> first two accepted, in_ready=0 after second. Raise out_ready -> outputs A001 then A002, then in_ready=1 and A003 is accepted; no loss.
- Flush in FULL: buffer holds two entries with reg_write_in=1, flush=1 with in_valid=1 -> next cycle out_valid=0, reg_write_out=0, instr_out=16'h0000, in_ready=1; flushed input never appears.
- Bubble masking: after reset, idle cycles -> reg_write_out=r0_write_out=w_enable_out=0, instr_out=NOP_INSTR; accept alu_op 4'hF, mux3_sel=1 -> fields appear with out_valid=1.
- Async reset mid-stall: FULL state, assert rst_n low between edges -> out_valid=0 and in_ready=0 immediately. After release, in_ready=1 at the next edge.
- Stats (macro defined): hold out_ready=0 for 5 cycles with a valid head, pulse flush twice -> stall_cnt=5, flush_cnt=2. Force 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: one instruction plus decoded controls, valid/ready handshake
// with a 2-entry skid buffer. Define PIPE_STAGE_BUF_STATS_EN to add stall/flush counters.
//   state | meaning
//   EMPTY | no valid entries
//   ONE   | main slot valid, drives outputs
//   FULL  | main and skid slots valid, in_ready low
module pipe_stage_buf #(
  parameter int                 INSTR_W     = 16,
  parameter int                 BRANCH_OP_W = 2,
  parameter int                 ALU_OP_W    = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_W-1:0]     instr_in,
  input  logic [BRANCH_OP_W-1:0] branch_op_in,
  input  logic [ALU_OP_W-1:0]    alu_op_in,
  input  logic                   mux3_sel_in,
  input  logic                   r0_write_in,
  input  logic                   reg_write_in,
  input  logic                   w_enable_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     instr_out,
  output logic [BRANCH_OP_W-1:0] branch_op_out,
  output logic [ALU_OP_W-1:0]    alu_op_out,
  output logic                   mux3_sel_out,
  output logic                   r0_write_out,
  output logic                   reg_write_out,
  output logic                   w_enable_out
`ifdef PIPE_STAGE_BUF_STATS_EN
  ,
  output logic [15:0]            stall_cnt,
  output logic [15:0]            flush_cnt
`endif
);

  localparam int PW = INSTR_W + BRANCH_OP_W + ALU_OP_W + 4;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] main_q, skid_q, payload_in;
  logic          ld_main, ld_skid, main_from_skid;
  logic          main_valid, skid_valid, accept, drain;

  logic [INSTR_W-1:0]     main_instr;
  logic [BRANCH_OP_W-1:0] main_branch_op;
  logic [ALU_OP_W-1:0]    main_alu_op;
  logic                   main_mux3, main_r0w, main_rw, main_we;

  assign payload_in = {instr_in, branch_op_in, alu_op_in,
                       mux3_sel_in, r0_write_in, reg_write_in, w_enable_in};
  assign {main_instr, main_branch_op, main_alu_op,
          main_mux3, main_r0w, main_rw, main_we} = main_q;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == FULL);
  assign accept     = in_valid && in_ready;
  assign drain      = main_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
      if (ld_main)             main_q <= payload_in;
      else if (main_from_skid) main_q <= skid_q;
      if (ld_skid)             skid_q <= payload_in;
    end
  end

  always_comb begin
    state_nxt      = state;
    ld_main        = 1'b0;
    ld_skid        = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      EMPTY: if (accept) begin
        state_nxt = ONE;
        ld_main   = 1'b1;
      end
      ONE: begin
        if (accept && drain) begin
          ld_main = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          ld_skid   = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      FULL: if (drain) begin
        state_nxt      = ONE;
        main_from_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
    // Squash wins over everything, including a same-cycle accept.
    if (flush) begin
      state_nxt      = EMPTY;
      ld_main        = 1'b0;
      ld_skid        = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  // Empty slots present a NOP with all write enables masked.
  assign out_valid     = main_valid;
  assign instr_out     = main_valid ? main_instr : NOP_INSTR;
  assign branch_op_out = main_branch_op;
  assign alu_op_out    = main_alu_op;
  assign mux3_sel_out  = main_mux3;
  assign r0_write_out  = main_valid && main_r0w;
  assign reg_write_out = main_valid && main_rw;
  assign w_enable_out  = main_valid && main_we;

`ifdef PIPE_STAGE_BUF_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf; stats checks compile in with
// PIPE_STAGE_BUF_STATS_EN.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] instr_in, instr_out;
  logic [1:0]  branch_op_in, branch_op_out;
  logic [3:0]  alu_op_in, alu_op_out;
  logic        mux3_sel_in, r0_write_in, reg_write_in, w_enable_in;
  logic        mux3_sel_out, r0_write_out, reg_write_out, w_enable_out;
`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_buf dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .branch_op_in(branch_op_in), .alu_op_in(alu_op_in),
    .mux3_sel_in(mux3_sel_in), .r0_write_in(r0_write_in),
    .reg_write_in(reg_write_in), .w_enable_in(w_enable_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr_out(instr_out), .branch_op_out(branch_op_out), .alu_op_out(alu_op_out),
    .mux3_sel_out(mux3_sel_out), .r0_write_out(r0_write_out),
    .reg_write_out(reg_write_out), .w_enable_out(w_enable_out)
`ifdef PIPE_STAGE_BUF_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    flush = 0; in_valid = 0; out_ready = 0; instr_in = '0;
    branch_op_in = '0; alu_op_in = '0; mux3_sel_in = 0;
    r0_write_in = 0; reg_write_in = 0; w_enable_in = 0;
    rst_n = 1'b0;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_instr", instr_out, 16'h0000);
    do_reset();
    chk("ready_after_rst", in_ready, 1);

    // bubble masking while idle
    chk("idle_rw", reg_write_out, 0);
    chk("idle_r0w", r0_write_out, 0);
    chk("idle_we", w_enable_out, 0);
    chk("idle_instr", instr_out, 16'h0000);

    // streaming
    out_ready = 1; in_valid = 1;
    instr_in = 16'h1234; tick();
    chk("s1_instr", instr_out, 16'h1234); chk("s1_valid", out_valid, 1); chk("s1_ready", in_ready, 1);
    instr_in = 16'h5678; tick();
    chk("s2_instr", instr_out, 16'h5678); chk("s2_valid", out_valid, 1); chk("s2_ready", in_ready, 1);
    instr_in = 16'h9ABC; tick();
    chk("s3_instr", instr_out, 16'h9ABC); chk("s3_valid", out_valid, 1); chk("s3_ready", in_ready, 1);
    in_valid = 0; tick();
    chk("s_end_valid", out_valid, 0);
    chk("s_end_instr", instr_out, 16'h0000);

    // back-pressure
    out_ready = 0; in_valid = 1;
    instr_in = 16'hA001; tick();
    chk("bp1_instr", instr_out, 16'hA001); chk("bp1_ready", in_ready, 1);
    instr_in = 16'hA002; tick();
    chk("bp2_instr", instr_out, 16'hA001); chk("bp2_ready", in_ready, 0);
    instr_in = 16'hA003; tick();
    chk("bp3_instr", instr_out, 16'hA001); chk("bp3_ready", in_ready, 0);
    out_ready = 1; tick();
    chk("bp4_instr", instr_out, 16'hA002); chk("bp4_ready", in_ready, 1);
    tick();
    chk("bp5_instr", instr_out, 16'hA003); chk("bp5_valid", out_valid, 1);
    in_valid = 0; tick();
    chk("bp6_valid", out_valid, 0);

    // flush while FULL
    out_ready = 0; in_valid = 1; reg_write_in = 1;
    instr_in = 16'hB001; tick();
    instr_in = 16'hB002; tick();
    chk("fl_full_ready", in_ready, 0);
    chk("fl_pre_rw", reg_write_out, 1);
    instr_in = 16'hB003; flush = 1; tick();
    chk("fl_valid", out_valid, 0); chk("fl_rw", reg_write_out, 0);
    chk("fl_instr", instr_out, 16'h0000); chk("fl_ready", in_ready, 1);
    // flush coinciding with an accept from EMPTY drops it too
    instr_in = 16'hC001; tick();
    chk("fl2_valid", out_valid, 0);
    flush = 0; in_valid = 0; reg_write_in = 0; tick();
    chk("fl3_valid", out_valid, 0); chk("fl3_instr", instr_out, 16'h0000);

    // control fields pass through, then hold masked after drain
    in_valid = 1; instr_in = 16'hD00D; alu_op_in = 4'hF; mux3_sel_in = 1;
    branch_op_in = 2'b10; w_enable_in = 1; r0_write_in = 1; tick();
    chk("bm_valid", out_valid, 1); chk("bm_alu", alu_op_out, 4'hF);
    chk("bm_mux3", mux3_sel_out, 1); chk("bm_br", branch_op_out, 2'b10);
    chk("bm_we", w_enable_out, 1); chk("bm_r0w", r0_write_out, 1);
    in_valid = 0; alu_op_in = 4'h3; w_enable_in = 0; r0_write_in = 0; out_ready = 1; tick();
    chk("bm_drained_valid", out_valid, 0); chk("bm_hold_alu", alu_op_out, 4'hF);
    chk("bm_mask_we", w_enable_out, 0); chk("bm_mask_r0w", r0_write_out, 0);
    mux3_sel_in = 0; branch_op_in = '0; alu_op_in = '0;

    // async reset in FULL
    out_ready = 0; in_valid = 1;
    instr_in = 16'hE001; tick();
    instr_in = 16'hE002; tick();
    chk("ar_full_valid", out_valid, 1);
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0); chk("ar_ready", in_ready, 0); chk("ar_instr", instr_out, 16'h0000);
    #3 rst_n = 1'b1;
    #1 chk("ar_ready_pre_edge", in_ready, 0);
    tick();
    chk("ar_ready_post", in_ready, 1); chk("ar_valid_post", out_valid, 0);

`ifdef PIPE_STAGE_BUF_STATS_EN
    chk("st_rst_stall", stall_cnt, 0);
    chk("st_rst_flush", flush_cnt, 0);
    out_ready = 0; in_valid = 1; instr_in = 16'hF001; tick();
    in_valid = 0;
    repeat (5) tick();
    chk("st_stall5", stall_cnt, 5);
    flush = 1; tick();
    flush = 0; tick();
    flush = 1; tick();
    flush = 0; tick();
    chk("st_flush2", flush_cnt, 2);
    chk("st_stall6", stall_cnt, 6);
    in_valid = 1; instr_in = 16'hF002; tick();
    in_valid = 0;
    repeat (70000) @(posedge clk);
    #1;
    chk("st_sat", stall_cnt, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
